// File: rtl/mfcc_frame_packer_if.sv
// Byte-stream link between the MFCC core, the frame packer and the SPI byte FIFO.
// The master side produces frames and FIFO status; the slave side is the packer.
interface mfcc_frame_packer_if #(
  parameter int NUM_COEFFS = 12,
  parameter int COEF_WIDTH = 16,
  parameter int DROP_CNT_W = 8
);
  logic                             mfcc_done_i;
  logic [NUM_COEFFS*COEF_WIDTH-1:0] coef_i;
  logic                             fifo_full_i;
  logic                             fifo_wr_en_o;
  logic [7:0]                       fifo_data_o;
  logic                             busy_o;
  logic                             packet_done_o;
  logic [7:0]                       seq_o;
  logic [DROP_CNT_W-1:0]            drop_cnt_o;

  modport master (
    output mfcc_done_i, coef_i, fifo_full_i,
    input  fifo_wr_en_o, fifo_data_o, busy_o, packet_done_o, seq_o, drop_cnt_o
  );

  modport slave (
    input  mfcc_done_i, coef_i, fifo_full_i,
    output fifo_wr_en_o, fifo_data_o, busy_o, packet_done_o, seq_o, drop_cnt_o
  );
endinterface

// File: rtl/mfcc_frame_packer.sv
// Packs a full MFCC frame into a self-delimiting byte packet for the SPI FIFO:
// sync header, sequence number, coefficients LSB-first, XOR checksum.
module mfcc_frame_packer #(
  parameter int          NUM_COEFFS = 12,
  parameter int          COEF_WIDTH = 16,
  parameter logic [7:0]  SYNC0      = 8'hA5,
  parameter logic [7:0]  SYNC1      = 8'h5A,
  parameter int          DROP_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mfcc_frame_packer_if.slave  bus
);

  localparam int PKT_LEN = 2*NUM_COEFFS + 4;
  localparam int IDX_W   = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PKT_LEN-1);
  localparam logic [IDX_W-1:0] CHK_FIRST = IDX_W'(2);
  localparam logic [IDX_W-1:0] CHK_LAST  = IDX_W'(PKT_LEN-2);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [7:0]                       chk_q, chk_d;
  logic [7:0]                       seq_q, seq_d;
  logic [7:0]                       pkt_seq_q, pkt_seq_d;
  logic [DROP_CNT_W-1:0]            drop_q, drop_d;
  logic [NUM_COEFFS*COEF_WIDTH-1:0] coef_q, coef_d;
  logic                             done_q, done_d;

  logic       wr_en;
  logic [7:0] cur_byte;
  logic       accept;
  logic       reject;
  logic [7:0] pkt_byte [PKT_LEN];

  // Packet image built from the latched frame; the checksum slot reads the running XOR.
  assign pkt_byte[0]         = SYNC0;
  assign pkt_byte[1]         = SYNC1;
  assign pkt_byte[2]         = pkt_seq_q;
  assign pkt_byte[PKT_LEN-1] = chk_q;

  generate
    for (genvar gi = 0; gi < NUM_COEFFS; gi++) begin : g_coef_bytes
      assign pkt_byte[3+2*gi] = coef_q[gi*COEF_WIDTH +: 8];
      assign pkt_byte[4+2*gi] = coef_q[gi*COEF_WIDTH+8 +: 8];
    end
  endgenerate

  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < PKT_LEN; i++) begin
      if (idx_q == IDX_W'(i)) cur_byte = pkt_byte[i];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      chk_q     <= '0;
      seq_q     <= '0;
      pkt_seq_q <= '0;
      drop_q    <= '0;
      coef_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      seq_q     <= seq_d;
      pkt_seq_q <= pkt_seq_d;
      drop_q    <= drop_d;
      coef_q    <= coef_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    seq_d     = seq_q;
    pkt_seq_d = pkt_seq_q;
    drop_d    = drop_q;
    coef_d    = coef_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;

    case (state_q)
      IDLE: begin
        accept = bus.mfcc_done_i;
      end
      SEND: begin
        if (wr_en && (idx_q == LAST_IDX)) begin
          // A frame arriving on the final write chains straight into the next packet.
          done_d  = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
          accept  = bus.mfcc_done_i;
        end else begin
          reject = bus.mfcc_done_i;
          if (wr_en) begin
            idx_d = idx_q + IDX_W'(1);
            if ((idx_q >= CHK_FIRST) && (idx_q <= CHK_LAST)) chk_d = chk_q ^ cur_byte;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d   = SEND;
      idx_d     = '0;
      chk_d     = '0;
      coef_d    = bus.coef_i;
      pkt_seq_d = seq_q;
      seq_d     = seq_q + 8'd1;
    end

    if (reject && (drop_q != {DROP_CNT_W{1'b1}})) drop_d = drop_q + DROP_CNT_W'(1);
  end

  // Outputs; the FIFO full flag feeds the write strobe combinationally.
  always_comb begin
    wr_en             = (state_q == SEND) && !bus.fifo_full_i;
    bus.fifo_wr_en_o  = wr_en;
    bus.fifo_data_o   = (state_q == SEND) ? cur_byte : 8'h00;
    bus.busy_o        = (state_q == SEND);
    bus.packet_done_o = done_q;
    bus.seq_o         = seq_q;
    bus.drop_cnt_o    = drop_q;
  end

endmodule

// File: doc/mfcc_frame_packer.md
Name: mfcc_frame_packer

Overview:
- Sits between MFCC_Core and the SPI transmit FIFO, and replaces the current path that writes only coefficient 11.
- On each mfcc_done pulse, latches all NUM_COEFFS coefficients.
- Emits one self-delimiting byte packet into the byte FIFO: sync header, sequence number, coefficients LSB-first, XOR checksum.
- The host resynchronises on the header after any loss.

Parameters:
NUM_COEFFS, 12, number of MFCC coefficients per frame
COEF_WIDTH, 16, bits per coefficient (fixed at 16; two bytes each)
SYNC0, 8'hA5, first header byte
SYNC1, 8'h5A, second header byte
DROP_CNT_W, 8, width of saturating dropped-frame counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
mfcc_done_i  input  1  one-cycle pulse; coefficients valid this cycle
coef_i  input  NUM_COEFFS*COEF_WIDTH  coefficient k at bits [k*16+:16]
fifo_full_i  input  1  byte FIFO full
fifo_wr_en_o  output  1  byte write strobe to FIFO
fifo_data_o  output  8  byte to FIFO
busy_o  output  1  packet in progress
packet_done_o  output  1  one-cycle pulse after last byte written
seq_o  output  8  sequence number of the next accepted frame
drop_cnt_o  output  DROP_CNT_W  frames rejected while busy (saturating)

Behaviour:
- Reset is one clock, asynchronous and active-low. It clears all state and outputs immediately:
  - state=IDLE, byte index=0, checksum=0, seq=0, drop_cnt=0.
  - busy_o=0, packet_done_o=0, fifo_wr_en_o=0, fifo_data_o=0.
  - Reset mid-packet abandons the remainder. Bytes already in the FIFO stay; the host discards the partial packet by header search.
- Packet is L = 2*NUM_COEFFS+4 bytes (28 at default). Index i layout:
  - i=0: SYNC0.
  - i=1: SYNC1.
  - i=2: seq.
  - i=3+2k: coef k [7:0].
  - i=4+2k: coef k [15:8].
  - i=L-1: XOR of bytes 2..L-2.
- States:
  - IDLE: if mfcc_done_i, latch coef_i and the current seq, set idx=0, chk=0, go to SEND, and increment seq (mod 256).
  - SEND:
    - fifo_data_o = combinational mux of the latched frame at idx.
    - fifo_wr_en_o = SEND && !fifo_full_i.
    - On each edge with fifo_wr_en_o=1: idx++. While idx is in 2..L-2, chk ^= byte.
    - After the write at idx=L-1: packet_done_o=1 next cycle and go to IDLE.
- Back-to-back frames:
  - mfcc_done_i in the same cycle the last byte is written is accepted. The next packet starts with no IDLE gap, and packet_done_o still pulses.
- Overrun:
  - mfcc_done_i at any other time in SEND: frame dropped, drop_cnt++ saturating at all-ones.
  - seq is not incremented for dropped frames. seq gaps therefore mean FIFO-side loss only.
- Backpressure:
  - fifo_full_i stalls with no byte loss and no timeout; idx and data hold.
  - fifo_full_i is sampled combinationally, so it must be driven by a registered full flag.
- busy_o = (state==SEND).
- Latency: mfcc_done_i at edge N means the first byte is written at edge N+1 if not full. An unstalled packet takes L cycles.
- Coefficient inputs may change after the capture cycle without affecting the packet in flight.

Test Plan:
- Basic packet: after reset, coef k=16'h0100+k, one mfcc_done, full=0 -> exactly 28 consecutive writes.
  - Bytes: A5 5A 00 00 01 01 01 02 01 … 0B 01, then checksum = XOR of bytes 2..26.
  - packet_done_o pulses once; seq_o=1.
- Backpressure: hold fifo_full_i=1 for cycles 5–14 of a packet -> no writes during the stall, bytes identical to the unstalled case, total duration 38 cycles.
- Overrun: second mfcc_done 10 cycles into a packet -> drop_cnt_o=1, seq_o=1, only one 28-byte packet emitted. Repeat 300 times -> drop_cnt_o saturates at 255.
- Back-to-back: mfcc_done coincident with the last-byte write -> second packet starts next cycle with seq byte 01, drop_cnt_o=0.
- Reset mid-packet: assert rst_n low at byte 12 -> wr_en and busy drop immediately. After release, the next mfcc_done emits a full packet with seq byte 00.
- Sequence wrap: 257 accepted frames -> seq bytes run 00..FF then 00, checksum correct for each packet.
